// File: rtl/ssp_tx_param_if.sv
// Write-side bus of the SSP transmit channel: select, write strobe and the word to queue.
// The master drives the strobes and the channel samples them through the slave modport.
interface ssp_tx_if #(
   parameter int DATA_W = 8
) ();
   logic              psel;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;

   modport master (output psel, pwrite, pwdata);
   modport slave  (input  psel, pwrite, pwdata);
endinterface

// File: rtl/ssp_tx_param.sv
// SSP transmit channel: write FIFO feeding a TI-style serializer (one-period frame sync,
// data MSB first), with back-to-back frame chaining while the FIFO holds words.
module ssp_tx_param #(
   parameter  int DATA_W    = 8,
   parameter  int DEPTH     = 4,
   parameter  int CLK_DIV   = 1,
   parameter  int TX_THRESH = 1,
   localparam int LVL_W     = $clog2(DEPTH) + 1
) (
   input  logic             pclk,
   input  logic             clear,
   ssp_tx_if.slave          bus,
   output logic [LVL_W-1:0] tx_level,
   output logic             tx_ovf,
   output logic             ssptxintr,
   output logic             sspoe_b,
   output logic             ssptxd,
   output logic             sspclkout,
   output logic             sspfssout
);

   localparam int PTR_W = LVL_W - 1;
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BC_W  = $clog2(DATA_W);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] LVL_THR  = LVL_W'(TX_THRESH);
   localparam logic [BC_W-1:0]  BC_START = BC_W'(DATA_W - 1);
   localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SYNC  = 2'd1,
      S_SHIFT = 2'd2,
      S_LAST  = 2'd3
   } state_t;

   // serial clock divider
   logic [CNT_W-1:0] cnt;
   logic             tick;

   always_ff @(posedge pclk) begin
      if (clear) begin
         cnt       <= '0;
         sspclkout <= 1'b0;
      end else if (cnt == CNT_MAX) begin
         cnt       <= '0;
         sspclkout <= ~sspclkout;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CNT_MAX) && !sspclkout;

   // write FIFO
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              wr_req;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] head;

   assign wr_req     = bus.psel && bus.pwrite;
   assign fifo_full  = (tx_level == LVL_FULL);
   assign fifo_empty = (tx_level == '0);
   // fullness is judged on the pre-edge level, so a pop on the same edge never rescues a write
   assign push       = wr_req && !fifo_full;
   assign head       = mem[rd_ptr];
   assign ssptxintr  = (tx_level <= LVL_THR);

   always_ff @(posedge pclk) begin
      if (push) begin
         mem[wr_ptr] <= bus.pwdata;
      end
   end

   always_ff @(posedge pclk) begin
      if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_level <= '0;
         tx_ovf   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   tx_level <= tx_level + 1'b1;
            2'b01:   tx_level <= tx_level - 1'b1;
            default: tx_level <= tx_level;
         endcase
         if (wr_req && fifo_full) begin
            tx_ovf <= 1'b1;
         end
      end
   end

   // serializer FSM, advanced only on serial-clock rising ticks
   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic [BC_W-1:0]   bitcnt;
   logic [BC_W-1:0]   bitcnt_nxt;
   logic              oe_nxt;
   logic              txd_nxt;
   logic              fss_nxt;

   always_ff @(posedge pclk) begin
      if (clear) begin
         state     <= S_IDLE;
         bitcnt    <= '0;
         sspoe_b   <= 1'b1;
         ssptxd    <= 1'b0;
         sspfssout <= 1'b0;
      end else if (tick) begin
         state     <= state_nxt;
         bitcnt    <= bitcnt_nxt;
         sspoe_b   <= oe_nxt;
         ssptxd    <= txd_nxt;
         sspfssout <= fss_nxt;
      end
   end

   always_ff @(posedge pclk) begin
      if (tick) begin
         shreg <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      bitcnt_nxt = bitcnt;
      oe_nxt     = sspoe_b;
      txd_nxt    = ssptxd;
      fss_nxt    = sspfssout;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            txd_nxt = 1'b0;
            if (!fifo_empty) begin
               pop       = tick;
               shreg_nxt = head;
               fss_nxt   = 1'b1;
               oe_nxt    = 1'b0;
               state_nxt = S_SYNC;
            end else begin
               fss_nxt = 1'b0;
               oe_nxt  = 1'b1;
            end
         end
         S_SYNC: begin
            fss_nxt    = 1'b0;
            txd_nxt    = shreg[DATA_W-1];
            bitcnt_nxt = BC_START;
            state_nxt  = S_SHIFT;
         end
         S_SHIFT: begin
            shreg_nxt  = {shreg[DATA_W-2:0], 1'b0};
            txd_nxt    = shreg[DATA_W-2];
            bitcnt_nxt = bitcnt - 1'b1;
            if (bitcnt == BC_ONE) begin
               // LSB goes out now; a waiting word is loaded so its sync overlaps the LSB
               if (!fifo_empty) begin
                  pop       = tick;
                  shreg_nxt = head;
                  fss_nxt   = 1'b1;
                  state_nxt = S_SYNC;
               end else begin
                  fss_nxt   = 1'b0;
                  state_nxt = S_LAST;
               end
            end
         end
         S_LAST: begin
            oe_nxt    = 1'b1;
            txd_nxt   = 1'b0;
            fss_nxt   = 1'b0;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ssp_tx_param.sv
// Directed bench for ssp_tx_param: a cycle table for a single frame plus hand-written
// sequences for chaining, overflow, threshold, wide-word and mid-frame reset cases.
module tb_ssp_tx_param;

   logic pclk;
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int n_cmp = 0;
   int n_bad = 0;

   // default instance
   logic       clr0;
   logic [2:0] lvl0;
   logic       ovf0, intr0, oe0, txd0, clk0, fss0;
   ssp_tx_if #(.DATA_W(8)) bus0 ();
   ssp_tx_param #(.DATA_W(8), .DEPTH(4), .CLK_DIV(1), .TX_THRESH(1)) dut0 (
      .pclk(pclk), .clear(clr0), .bus(bus0.slave), .tx_level(lvl0), .tx_ovf(ovf0),
      .ssptxintr(intr0), .sspoe_b(oe0), .ssptxd(txd0), .sspclkout(clk0), .sspfssout(fss0));

   // slow divider instance
   logic       clr1;
   logic [2:0] lvl1;
   logic       ovf1, intr1, oe1, txd1, clk1, fss1;
   ssp_tx_if #(.DATA_W(8)) bus1 ();
   ssp_tx_param #(.DATA_W(8), .DEPTH(4), .CLK_DIV(8), .TX_THRESH(1)) dut1 (
      .pclk(pclk), .clear(clr1), .bus(bus1.slave), .tx_level(lvl1), .tx_ovf(ovf1),
      .ssptxintr(intr1), .sspoe_b(oe1), .ssptxd(txd1), .sspclkout(clk1), .sspfssout(fss1));

   // wide word instance
   logic       clr2;
   logic [3:0] lvl2;
   logic       ovf2, intr2, oe2, txd2, clk2, fss2;
   ssp_tx_if #(.DATA_W(12)) bus2 ();
   ssp_tx_param #(.DATA_W(12), .DEPTH(8), .CLK_DIV(1), .TX_THRESH(1)) dut2 (
      .pclk(pclk), .clear(clr2), .bus(bus2.slave), .tx_level(lvl2), .tx_ovf(ovf2),
      .ssptxintr(intr2), .sspoe_b(oe2), .ssptxd(txd2), .sspclkout(clk2), .sspfssout(fss2));

   typedef struct {
      logic       clr;
      logic       sel;
      logic       wr;
      logic [7:0] wdata;
      logic [2:0] lvl;
      logic       ovf;
      logic       intr;
      logic       oe;
      logic       txd;
      logic       clk;
      logic       fss;
   } vec_t;

   vec_t vt [23];

   function automatic vec_t mk(input logic clr, input logic sel, input logic wr,
                               input logic [7:0] wdata, input logic [2:0] lvl,
                               input logic ovf, input logic intr, input logic oe,
                               input logic txd, input logic clk, input logic fss);
      vec_t v;
      v.clr = clr; v.sel = sel; v.wr = wr; v.wdata = wdata; v.lvl = lvl;
      v.ovf = ovf; v.intr = intr; v.oe = oe; v.txd = txd; v.clk = clk; v.fss = fss;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   function automatic logic [9:0] pack0();
      return {1'b0, lvl0, ovf0, intr0, oe0, txd0, clk0, fss0};
   endfunction

   function automatic int t5_level(input int e);
      if (e == 1) return 1;
      if (e <= 3) return 2;
      if (e <= 18) return 3;
      if (e <= 34) return 2;
      if (e <= 50) return 1;
      return 0;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [9:0]  exp_v;
      logic [11:0] word12;
      int          frames;
      int          t5_lvl;
      logic        prev_fss;
      logic        done;

      // single-frame table: clr sel wr data | lvl ovf intr oe txd clk fss
      vt[0]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
      vt[1]  = mk(0, 1, 1, 8'hA5, 1, 0, 1, 1, 0, 1, 0);
      vt[2]  = mk(0, 0, 1, 8'h5A, 1, 0, 1, 1, 0, 0, 0);
      vt[3]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1);
      vt[4]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1);
      vt[5]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0);
      vt[6]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0);
      vt[7]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0);
      vt[8]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
      vt[9]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0);
      vt[10] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0);
      vt[11] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0);
      vt[12] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
      vt[13] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0);
      vt[14] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
      vt[15] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0);
      vt[16] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0);
      vt[17] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0);
      vt[18] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
      vt[19] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0);
      vt[20] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0);
      vt[21] = mk(0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 0);
      vt[22] = mk(0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);

      clr0 = 1'b1; clr1 = 1'b1; clr2 = 1'b1;
      bus0.psel = 1'b0; bus0.pwrite = 1'b0; bus0.pwdata = '0;
      bus1.psel = 1'b0; bus1.pwrite = 1'b0; bus1.pwdata = '0;
      bus2.psel = 1'b0; bus2.pwrite = 1'b0; bus2.pwdata = '0;
      step();

      // reset held for three cycles in the middle of a frame
      clr0 = 1'b0;
      bus0.psel = 1'b1; bus0.pwrite = 1'b1; bus0.pwdata = 8'h3C;
      step();
      bus0.psel = 1'b0; bus0.pwrite = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk("t1_busy_oe", 32'(oe0), 32'd0);
      clr0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("t1_reset_%0d", i), 32'(pack0()), 32'b0_000_0_1_1_0_0_0);
      end

      // single 0xA5 frame, cycle by cycle
      for (int i = 0; i < 23; i++) begin
         clr0 = vt[i].clr;
         bus0.psel = vt[i].sel; bus0.pwrite = vt[i].wr; bus0.pwdata = vt[i].wdata;
         step();
         exp_v = {1'b0, vt[i].lvl, vt[i].ovf, vt[i].intr, vt[i].oe, vt[i].txd,
                  vt[i].clk, vt[i].fss};
         chk($sformatf("t2_vec%0d", i), 32'(pack0()), 32'(exp_v));
      end

      // 0xFF then 0x00 chained with no gap
      clr0 = 1'b1; bus0.psel = 1'b0; bus0.pwrite = 1'b0;
      step();
      clr0 = 1'b0;
      bus0.psel = 1'b1; bus0.pwrite = 1'b1; bus0.pwdata = 8'hFF;
      step();
      bus0.pwdata = 8'h00;
      step();
      bus0.psel = 1'b0; bus0.pwrite = 1'b0;
      chk("t3_level2", 32'(lvl0), 32'd2);
      for (int e = 3; e <= 38; e++) begin
         step();
         exp_v = '0;
         exp_v[2] = !(e >= 3 && e <= 36);
         exp_v[1] = (e >= 5 && e <= 20);
         exp_v[0] = (e >= 3 && e <= 4) || (e >= 19 && e <= 20);
         chk($sformatf("t3_e%0d", e), 32'({oe0, txd0, fss0}), 32'(exp_v[2:0]));
      end

      // threshold interrupt while filling to three words and draining
      clr0 = 1'b1;
      step();
      clr0 = 1'b0;
      for (int e = 1; e <= 56; e++) begin
         bus0.psel = (e <= 4); bus0.pwrite = (e <= 4); bus0.pwdata = 8'(e * 17);
         step();
         t5_lvl = t5_level(e);
         chk($sformatf("t5_lvl_e%0d", e), 32'(lvl0), 32'(t5_lvl));
         chk($sformatf("t5_intr_e%0d", e), 32'(intr0), 32'(t5_lvl <= 1));
      end
      bus0.psel = 1'b0; bus0.pwrite = 1'b0;

      // slow divider: overflow on the fifth back-to-back write
      clr1 = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         bus1.psel = 1'b1; bus1.pwrite = 1'b1; bus1.pwdata = 8'(8'h80 + e);
         step();
         chk($sformatf("t4_lvl_e%0d", e), 32'(lvl1), 32'((e < 4) ? e : 4));
         chk($sformatf("t4_ovf_e%0d", e), 32'(ovf1), 32'(e == 5));
      end
      bus1.psel = 1'b0; bus1.pwrite = 1'b0;
      step();
      step();
      chk("t4_e7", 32'({lvl1, fss1, clk1}), 32'({3'd4, 1'b0, 1'b0}));
      step();
      chk("t4_e8", 32'({lvl1, fss1, clk1, oe1}), 32'({3'd3, 1'b1, 1'b1, 1'b0}));
      frames = 1; prev_fss = 1'b1; done = 1'b0;
      for (int c = 0; c < 1500 && !done; c++) begin
         step();
         if (fss1 && !prev_fss) frames++;
         prev_fss = fss1;
         if (oe1) done = 1'b1;
      end
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_frames", 32'(frames), 32'd4);
      chk("t4_end", 32'({lvl1, ovf1}), 32'({3'd0, 1'b1}));

      // 12-bit word with clear after five data bits
      word12 = 12'hABC;
      clr2 = 1'b0;
      bus2.psel = 1'b1; bus2.pwrite = 1'b1; bus2.pwdata = word12;
      step();
      bus2.psel = 1'b0; bus2.pwrite = 1'b0;
      for (int e = 2; e <= 14; e++) begin
         step();
         if (e == 3) chk("t6_fss", 32'({fss2, oe2}), 32'({1'b1, 1'b0}));
         if (e >= 5) chk($sformatf("t6_bit_e%0d", e), 32'(txd2), 32'(word12[11 - (e - 5) / 2]));
      end
      clr2 = 1'b1;
      step();
      chk("t6_reset", 32'({lvl2, ovf2, oe2, txd2, clk2, fss2}),
          32'({4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
      clr2 = 1'b0;
      for (int e = 0; e < 40; e++) begin
         step();
         chk($sformatf("t6_quiet_%0d", e), 32'({oe2, txd2, fss2, lvl2}),
             32'({1'b1, 1'b0, 1'b0, 4'd0}));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
